uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte buffer that sits directly upstream of the UART transmitter in `uart_full`. It accepts bytes from the host side through a write strobe and stores them in a circular FIFO. A small launch FSM drains the FIFO one byte at a time into the transmitter's `tx_start`/`tx_data`/`tx_busy` handshake, so the host can burst up to DEPTH bytes without waiting on the 9600-baud line.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries, legal range 1..8.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe; one byte per cycle while high.
- `wr_data`  in  8  byte to enqueue, sampled when `wr_en`=1.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1  current occupancy.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `tx_start`  out  1  launch request to the transmitter.
- `tx_data`  out  8  byte being transmitted.
- `tx_busy`  in  1  transmitter busy flag.
- `ovf_count`  out  8  saturating dropped-byte counter. Present only with `UART_TX_FIFO_OVF_CNT_EN`.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 array with read and write pointers of width DEPTH_LOG2. Pointers wrap naturally modulo depth. `count` is a separate register.
- Write: accepted when `wr_en`=1 and `full`=0. The byte is written at the write pointer and the pointer increments.
- Write with `full`=1 is dropped. Array, pointers and count are unchanged, and `overflow` pulses for 1 cycle. `full` is evaluated on the registered count, so a write and a pop in the same cycle while full still drops the write.
- Pop: performed only by the FSM and only when `empty`=0. The pop reads the byte at the read pointer into the `tx_data` register and increments the read pointer.
- Simultaneous accepted write and pop: `count` is unchanged. Otherwise `count` changes by +1 or -1.
- FSM states:
  - IDLE: `tx_start`=0. If `empty`=0 and `tx_busy`=0, pop and go to LAUNCH.
  - LAUNCH: `tx_start`=1. Stay until `tx_busy`=1, then go to WAIT_DONE. `tx_start` is held because the transmitter may only start on its baud tick.
  - WAIT_DONE: `tx_start`=0. When `tx_busy`=0, go to IDLE.
- `tx_data` holds the popped byte from LAUNCH entry until the next pop. It never changes while `tx_start` or `tx_busy` is high.
- Reset values: pointers 0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `tx_start`=0, `tx_data`=8'h00, FSM=IDLE, `ovf_count`=0.
- Reset mid-transmission discards the in-flight byte and all queued bytes. The transmitter shares `rst`, so the line also returns to idle.

## Timing
- `full`, `empty` and `count` are registered. They reflect a write on the edge where it is accepted.
- Write to empty FIFO while idle: byte accepted at edge k, `empty`=0 after k. The FSM pops at edge k+1, and `tx_start`=1 with valid `tx_data` after k+1.
- Back-to-back bytes: the next pop occurs on the first edge where the FSM is in IDLE. That is one cycle after `tx_busy` is seen low in WAIT_DONE.
- `overflow` is high for exactly the cycle after the dropped write's edge.
- There is no combinational path from `wr_en` or `tx_busy` to any output.

## Configuration
- `UART_TX_FIFO_OVF_CNT_EN` defined:
  - `ovf_count` port exists.
  - It increments on every dropped write and saturates at 8'hFF.
  - It clears only on `rst`.
- Not defined: `ovf_count` port and its register are absent. `overflow` pulses are the only drop indication.

## Test plan
- Reset with `wr_en`=0: `empty`=1, `full`=0, `count`=0, `tx_start`=0, `tx_data`=8'h00.
- Single write 8'hA5 at edge k, transmitter model raises `tx_busy` 3 cycles after `tx_start` and holds it 20 cycles:
  - `tx_start`=1 after edge k+1, `tx_data`=8'hA5.
  - `tx_start` drops the cycle after `tx_busy` rises.
  - Returns to IDLE with `empty`=1.
- Burst writes 8'h01..8'h10 with DEPTH_LOG2=4: `full`=1 when `count` reaches 16, and the transmitter sees bytes 01..10 in order with no duplicates or gaps. Because the FSM pops 8'h01 one cycle after the first write, `full` asserts only if the transmitter holds `tx_busy` for the whole burst.
- Fill to 16, then write 8'hFF twice:
  - Two `overflow` pulses, `count` stays 16, 8'hFF is never transmitted.
  - With the macro defined, `ovf_count`=2.
  - With the macro defined, 300 extra dropped writes leave `ovf_count`=8'hFF.
- With `count`=5 mid-transmission, write and pop on the same edge: `count` stays 5. Then assert `rst` while `tx_busy`=1: all reset values are restored immediately and no further `tx_start` occurs.
- Wrap-around: 40 writes interleaved with drain at DEPTH_LOG2=2 produce all 40 bytes transmitted in order.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO in front of the UART transmitter. The host writes bytes with
//   wr_en/wr_data. A three-state launch FSM pops one byte at a time into
//   tx_data and holds tx_start until the transmitter reports tx_busy, then
//   waits for tx_busy to fall before it launches the next byte.
//
// Parameters
//   DEPTH_LOG2  FIFO depth is 2**DEPTH_LOG2 bytes (1..8)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   wr_en      write strobe, one byte per cycle
//   wr_data    byte to enqueue
//   full       occupancy == depth (registered)
//   empty      occupancy == 0 (registered)
//   count      occupancy, DEPTH_LOG2+1 bits (registered)
//   overflow   one-cycle pulse after a dropped write
//   tx_start   launch request to the transmitter
//   tx_data    byte being transmitted
//   tx_busy    transmitter busy flag
//   ovf_count  saturating dropped-write counter, only when
//              UART_TX_FIFO_OVF_CNT_EN is defined
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy
`ifdef UART_TX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]            ovf_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  wr_ok, wr_drop, pop;

  // Flags come straight off the count register, so a pop in the same
  // cycle cannot rescue a write issued while full.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign wr_drop = wr_en && full;

  // Launch FSM: next state and outputs
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_start  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        // Held until the transmitter answers; it may only start on a baud tick.
        tx_start = 1'b1;
        if (tx_busy) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Storage has no reset; every entry is written before it can be read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      overflow <= wr_drop;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        tx_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ovf_count <= 8'h00;
    else if (wr_drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h01;
  end
`endif

endmodule
